// File: rtl/cmsdk_ahb_bridge_arbiter2_if.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_ahb_bridge_arbiter2_if
// Function : Bus bundle for the two-master AHB-Lite bridge arbiter.
// Revision : 1.0
// ============================================================================
interface cmsdk_ahb_bridge_arbiter2_if;
    logic [1:0]  HTRANS0,    HTRANS1;
    logic [31:0] HADDR0,     HADDR1;
    logic        HWRITE0,    HWRITE1;
    logic [2:0]  HSIZE0,     HSIZE1;
    logic [3:0]  HPROT0,     HPROT1;
    logic        HMASTLOCK0, HMASTLOCK1;
    logic [31:0] HWDATA0,    HWDATA1;
    logic        HREADYOUT0, HREADYOUT1;
    logic        HRESP0,     HRESP1;
    logic [31:0] HRDATA0,    HRDATA1;

    logic        HSELB;
    logic [1:0]  HTRANSB;
    logic [31:0] HADDRB;
    logic        HWRITEB;
    logic [2:0]  HSIZEB;
    logic [3:0]  HPROTB;
    logic        HMASTLOCKB;
    logic [31:0] HWDATAB;
    logic        HREADYB;
    logic        HREADYOUTB;
    logic        HRESPB;
    logic [31:0] HRDATAB;
    logic        HMASTERB;

    // Arbiter view: slave to both masters, master to the bridge.
    modport slave (
        input  HTRANS0, HTRANS1, HADDR0, HADDR1, HWRITE0, HWRITE1,
               HSIZE0, HSIZE1, HPROT0, HPROT1, HMASTLOCK0, HMASTLOCK1,
               HWDATA0, HWDATA1, HREADYOUTB, HRESPB, HRDATAB,
        output HREADYOUT0, HREADYOUT1, HRESP0, HRESP1, HRDATA0, HRDATA1,
               HSELB, HTRANSB, HADDRB, HWRITEB, HSIZEB, HPROTB, HMASTLOCKB,
               HWDATAB, HREADYB, HMASTERB
    );

    // Environment view: the two masters plus the bridge slave port.
    modport master (
        output HTRANS0, HTRANS1, HADDR0, HADDR1, HWRITE0, HWRITE1,
               HSIZE0, HSIZE1, HPROT0, HPROT1, HMASTLOCK0, HMASTLOCK1,
               HWDATA0, HWDATA1, HREADYOUTB, HRESPB, HRDATAB,
        input  HREADYOUT0, HREADYOUT1, HRESP0, HRESP1, HRDATA0, HRDATA1,
               HSELB, HTRANSB, HADDRB, HWRITEB, HSIZEB, HPROTB, HMASTLOCKB,
               HWDATAB, HREADYB, HMASTERB
    );
endinterface
`default_nettype wire

// File: rtl/cmsdk_ahb_bridge_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_ahb_bridge_arbiter2
// Function : Round-robin, lock-aware arbiter sharing the bridge slave port
//            between two AHB-Lite masters; every transfer issued as a single.
// Revision : 1.0
// ============================================================================
module cmsdk_ahb_bridge_arbiter2 (
    input  logic                              HCLKS,
    input  logic                              HRESETS,
    cmsdk_ahb_bridge_arbiter2_if.slave        bus
);
    localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_FREE = 2'b00,   // no bridge data phase outstanding
        S_ADDR = 2'b01,   // NONSEQ held behind a stalled data phase
        S_DATA = 2'b10    // data phase outstanding
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        lock;
    } ctrl_t;

    state_t      r_state;
    logic        r_last_grant, r_gnt, r_lock_hold, r_lock_owner;
    logic        r_dp_owner, r_mst;
    logic [31:0] r_haddrb;
    logic        r_hwriteb;
    logic [2:0]  r_hsizeb;
    logic [3:0]  r_hprotb;

    logic [1:0]  w_htrans [2];
    ctrl_t       w_in     [2];
    ctrl_t       w_pend   [2];
    logic [31:0] w_hrdata [2];
    logic [1:0]  w_pend_vld, w_hreadyout, w_hresp, w_capture, w_idle_unlock, w_elig;
    logic        w_dp_vld, w_hreadyb, w_issue, w_accept, w_gnt;
    ctrl_t       w_bctrl;

    assign w_htrans[0] = bus.HTRANS0;
    assign w_htrans[1] = bus.HTRANS1;
    assign w_in[0] = {bus.HADDR0, bus.HWRITE0, bus.HSIZE0, bus.HPROT0, bus.HMASTLOCK0};
    assign w_in[1] = {bus.HADDR1, bus.HWRITE1, bus.HSIZE1, bus.HPROT1, bus.HMASTLOCK1};

    assign w_dp_vld  = (r_state != S_FREE);
    assign w_hreadyb = w_dp_vld ? bus.HREADYOUTB : 1'b1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic c_IDX = 1'(gi);
        logic  r_vld;
        ctrl_t r_ctrl;
        logic  w_own;

        assign w_own             = w_dp_vld & (r_dp_owner == c_IDX);
        assign w_hreadyout[gi]   = r_vld ? 1'b0 : (w_own ? bus.HREADYOUTB : 1'b1);
        assign w_hresp[gi]       = w_own & bus.HRESPB;
        assign w_hrdata[gi]      = w_own ? bus.HRDATAB : 32'h0;
        assign w_capture[gi]     = w_htrans[gi][1] & w_hreadyout[gi];
        assign w_idle_unlock[gi] = w_hreadyout[gi] & (w_htrans[gi] == c_TRANS_IDLE) & ~w_in[gi].lock;
        assign w_pend_vld[gi]    = r_vld;
        assign w_pend[gi]        = r_ctrl;

        // Holding register stays frozen while valid: HREADYOUT is low then.
        always_ff @(posedge HCLKS) begin
            if (HRESETS) begin
                r_vld  <= 1'b0;
                r_ctrl <= '0;
            end else if (w_capture[gi]) begin
                r_vld  <= 1'b1;
                r_ctrl <= w_in[gi];
            end else if (w_accept && (w_gnt == c_IDX)) begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign w_elig[0] = w_pend_vld[0] & (~r_lock_hold | ~r_lock_owner);
    assign w_elig[1] = w_pend_vld[1] & (~r_lock_hold |  r_lock_owner);

    // A NONSEQ held against a stalled data phase keeps its owner.
    always_comb begin
        w_gnt = r_last_grant;
        if (r_state == S_ADDR) begin
            w_gnt = r_gnt;
        end else if (&w_elig) begin
            w_gnt = ~r_last_grant;
        end else begin
            w_gnt = w_elig[1];
        end
    end

    assign w_issue  = (r_state == S_ADDR) | (|w_elig);
    assign w_accept = w_issue & w_hreadyb;
    assign w_bctrl  = w_pend[w_gnt];

    always_ff @(posedge HCLKS) begin
        if (HRESETS) begin
            r_state      <= S_FREE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_lock_hold  <= 1'b0;
            r_lock_owner <= 1'b0;
            r_dp_owner   <= 1'b0;
            r_mst        <= 1'b0;
            r_haddrb     <= 32'h0;
            r_hwriteb    <= 1'b0;
            r_hsizeb     <= 3'b000;
            r_hprotb     <= 4'b0000;
        end else if (w_accept) begin
            r_state      <= S_DATA;
            r_last_grant <= w_gnt;
            r_dp_owner   <= w_gnt;
            r_mst        <= w_gnt;
            r_lock_hold  <= w_bctrl.lock;
            r_lock_owner <= w_gnt;
            r_haddrb     <= w_bctrl.addr;
            r_hwriteb    <= w_bctrl.write;
            r_hsizeb     <= w_bctrl.size;
            r_hprotb     <= w_bctrl.prot;
        end else begin
            if (w_issue) begin
                r_state <= S_ADDR;
                r_gnt   <= w_gnt;
            end else if (w_dp_vld && bus.HREADYOUTB) begin
                r_state <= S_FREE;
            end
            if (r_lock_hold && w_idle_unlock[r_lock_owner]) begin
                r_lock_hold <= 1'b0;
            end
        end
    end

    assign bus.HSELB      = w_issue;
    assign bus.HTRANSB    = w_issue ? c_TRANS_NONSEQ : c_TRANS_IDLE;
    assign bus.HADDRB     = w_issue ? w_bctrl.addr  : r_haddrb;
    assign bus.HWRITEB    = w_issue ? w_bctrl.write : r_hwriteb;
    assign bus.HSIZEB     = w_issue ? w_bctrl.size  : r_hsizeb;
    assign bus.HPROTB     = w_issue ? w_bctrl.prot  : r_hprotb;
    assign bus.HMASTLOCKB = w_issue ? w_bctrl.lock  : r_lock_hold;
    assign bus.HMASTERB   = w_issue ? w_gnt         : r_mst;
    assign bus.HREADYB    = w_hreadyb;
    assign bus.HWDATAB    = w_dp_vld ? (r_dp_owner ? bus.HWDATA1 : bus.HWDATA0) : 32'h0;

    assign bus.HREADYOUT0 = w_hreadyout[0];
    assign bus.HREADYOUT1 = w_hreadyout[1];
    assign bus.HRESP0     = w_hresp[0];
    assign bus.HRESP1     = w_hresp[1];
    assign bus.HRDATA0    = w_hrdata[0];
    assign bus.HRDATA1    = w_hrdata[1];
endmodule
`default_nettype wire
